// File: rtl/mem_pkg.sv
// Shared types and helpers for the RAM port arbiter: FSM encoding, master IDs,
// byte-lane constants and the read-modify-write merge.
package mem_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_DEPTH = 256;
  localparam int unsigned BE_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    MERGE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic MID_IF = 1'b0;
  localparam logic MID_DM = 1'b1;

  localparam logic [BE_W-1:0] FULL_BE = 4'hF;

  // Per byte lane: take the new lane where be is set, otherwise keep the old lane.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int i = 0; i < int'(BE_W); i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant; on contention the master not granted last wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_if,
  input  logic req_dm,
  input  logic en,
  output logic gnt_valid_c,
  output logic gnt_id_c
);

  logic last_grant_q;

  always_comb begin
    gnt_valid_c = req_if | req_dm;
    gnt_id_c    = (req_if && req_dm) ? ~last_grant_q : req_dm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= MID_IF;
    end else if (en && gnt_valid_c) begin
      last_grant_q <= gnt_id_c;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port combinational-read RAM between instruction fetch and the
// data LSU; sub-word stores become read-modify-write.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DataWidth = DATA_W,
  parameter int unsigned AddrWidth = ADDR_W,
  parameter int unsigned DataDepth = DATA_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_ack,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [3:0]           dm_be,
  input  logic [AddrWidth-1:0] dm_addr,
  input  logic [DataWidth-1:0] dm_wdata,
  output logic                 dm_ack,
  output logic [DataWidth-1:0] rdata,
  output logic                 err,
  output logic                 busy,
  output logic [AddrWidth-1:0] ram_addr,
  output logic                 ram_r,
  output logic                 ram_w,
  output logic [DataWidth-1:0] ram_wdata,
  input  logic [DataWidth-1:0] ram_rdata
);

  localparam logic [AddrWidth-1:0] ADDR_LIMIT = AddrWidth'(4 * DataDepth);

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   we_q, we_d;
  logic [3:0]             be_q, be_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   id_q, id_d;
  logic                   oor_q, oor_d;

  logic                   if_ack_d, dm_ack_d, err_d, busy_d, ram_r_d, ram_w_d;
  logic [DataWidth-1:0]   rdata_d, ram_wdata_d;
  logic                   partial_d;
  logic                   gnt_valid_c, gnt_id_c;

  rr_arb2 u_arb (
    .clk         (CLK),
    .rst_n       (RST_n),
    .req_if      (if_req),
    .req_dm      (dm_req),
    .en          (state_q == IDLE),
    .gnt_valid_c (gnt_valid_c),
    .gnt_id_c    (gnt_id_c)
  );

  // Next state and request latch; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    id_d    = id_q;
    oor_d   = oor_q;
    rdata_d = rdata;

    case (state_q)
      IDLE: begin
        if (gnt_valid_c) begin
          id_d    = gnt_id_c;
          state_d = ACC;
          if (gnt_id_c == MID_DM) begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            be_d    = dm_be;
            wdata_d = dm_wdata;
          end else begin
            addr_d  = if_addr;
            we_d    = 1'b0;
            be_d    = '0;
            wdata_d = '0;
          end
          oor_d = (addr_d >= ADDR_LIMIT);
        end
      end
      ACC: begin
        rdata_d = (!we_q && !oor_q) ? ram_rdata : '0;
        if (!oor_q && we_q && be_q != FULL_BE && be_q != 4'h0) state_d = MERGE;
        else                                                   state_d = RESP;
      end
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    partial_d   = we_d && be_d != FULL_BE && be_d != 4'h0;
    ram_r_d     = (state_d == ACC) && !oor_d && (!we_d || partial_d);
    ram_w_d     = ((state_d == ACC) && !oor_d && we_d && be_d == FULL_BE) ||
                  (state_d == MERGE);
    // Entering MERGE from ACC: ram_rdata still holds the old word read this cycle.
    if (state_d == MERGE) ram_wdata_d = byte_merge(ram_rdata, wdata_q, be_q);
    else if (ram_w_d)     ram_wdata_d = wdata_d;
    else                  ram_wdata_d = '0;
    if_ack_d    = (state_d == RESP) && (id_d == MID_IF);
    dm_ack_d    = (state_d == RESP) && (id_d == MID_DM);
    err_d       = (state_d == RESP) && oor_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      id_q      <= MID_IF;
      oor_q     <= 1'b0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      ram_addr  <= '0;
      ram_r     <= 1'b0;
      ram_w     <= 1'b0;
      ram_wdata <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      id_q      <= id_d;
      oor_q     <= oor_d;
      if_ack    <= if_ack_d;
      dm_ack    <= dm_ack_d;
      rdata     <= rdata_d;
      err       <= err_d;
      busy      <= busy_d;
      ram_addr  <= addr_d;
      ram_r     <= ram_r_d;
      ram_w     <= ram_w_d;
      ram_wdata <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 256-word RAM.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [3:0]  dm_be = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;
  logic [31:0] ram_addr;
  logic        ram_r;
  logic        ram_w;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [256];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int nvec = 0;
  int nfail = 0;
  int r_cnt = 0;
  int w_cnt = 0;
  logic [31:0] w_data = '0;

  always #5 CLK = ~CLK;

  mem_port_arbiter dut (
    .CLK(CLK), .RST_n(RST_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .rdata(rdata), .err(err), .busy(busy),
    .ram_addr(ram_addr), .ram_r(ram_r), .ram_w(ram_w),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = (ram_addr < 32'h400) ? mem[ram_addr[9:2]] : 32'h0;

  always @(posedge CLK) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (ram_w && ram_addr < 32'h400) mem[ram_addr[9:2]] <= ram_wdata;
  end

  // Strobe counters and scoreboard pop on every ack.
  always @(negedge CLK) begin
    exp_t e;
    if (ram_r) r_cnt++;
    if (ram_w) begin w_cnt++; w_data = ram_wdata; end
    if (ram_r && ram_w) begin
      nvec++; nfail++;
      $display("FAIL strobe_overlap: ram_r=%b ram_w=%b, required not both high", ram_r, ram_w);
    end
    if (if_ack || dm_ack) begin
      nvec++;
      if (if_ack && dm_ack) begin
        nfail++;
        $display("FAIL double_ack: if_ack=1 dm_ack=1, required one at a time");
      end else if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_ack: if_ack=%b dm_ack=%b with empty scoreboard", if_ack, dm_ack);
      end else begin
        e = exp_q.pop_front();
        if ({dm_ack, rdata, err} !== {e.id, e.rdata, e.err}) begin
          nfail++;
          $display("FAIL ack_payload: got id=%b rdata=%h err=%b, required id=%b rdata=%h err=%b",
                   dm_ack, rdata, err, e.id, e.rdata, e.err);
        end
      end
    end
  end

  task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
    @(posedge CLK); #1;
    bd_idx = idx; bd_data = data; bd_we = 1'b1;
    @(posedge CLK); #1;
    bd_we = 1'b0;
  endtask

  task automatic access(input logic id, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] erd, input logic eerr, input int elat,
                        input string name);
    int n;
    bit got;
    exp_q.push_back('{id: id, rdata: erd, err: eerr});
    r_cnt = 0; w_cnt = 0; w_data = '0;
    @(posedge CLK); #1;
    if (id) begin
      dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    n = 0; got = 0;
    while (!got && n < 12) begin
      @(negedge CLK);
      n++;
      if (id ? dm_ack : if_ack) got = 1;
    end
    nvec++;
    if (!got) begin
      nfail++;
      void'(exp_q.pop_back());
      $display("FAIL %s_timeout: no ack after %0d cycles, required ack in cycle %0d", name, n, elat);
    end else if (n != elat) begin
      nfail++;
      $display("FAIL %s_latency: ack in cycle %0d, required cycle %0d", name, n, elat);
    end
    @(posedge CLK); #1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    nvec++;
    if ({if_ack, dm_ack, rdata, err, busy, ram_addr, ram_r, ram_w, ram_wdata} !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: ack=%b%b rdata=%h err=%b busy=%b addr=%h r=%b w=%b wd=%h, required all 0",
               if_ack, dm_ack, rdata, err, busy, ram_addr, ram_r, ram_w, ram_wdata);
    end
    @(negedge CLK); RST_n = 1'b1;
  endtask

  task automatic test_if_fetch();
    bd_write(8'd3, 32'h1234_5678);
    access(1'b0, 1'b0, 4'h0, 32'h0C, 32'h0, 32'h1234_5678, 1'b0, 3, "if_fetch");
    nvec++;
    if (r_cnt != 1 || w_cnt != 0) begin
      nfail++;
      $display("FAIL if_fetch_strobes: r=%0d w=%0d, required r=1 w=0", r_cnt, w_cnt);
    end
  endtask

  task automatic test_full_store_load();
    access(1'b1, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, "full_store");
    nvec++;
    if (r_cnt != 0 || w_cnt != 1 || w_data !== 32'hDEAD_BEEF) begin
      nfail++;
      $display("FAIL full_store_strobes: r=%0d w=%0d wdata=%h, required r=0 w=1 wdata=deadbeef",
               r_cnt, w_cnt, w_data);
    end
    access(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, "load_back");
  endtask

  task automatic test_partial_store();
    access(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_AA00, 32'h0, 1'b0, 4, "partial_store");
    nvec++;
    if (r_cnt != 1 || w_cnt != 1 || w_data !== 32'hDEAD_AAEF) begin
      nfail++;
      $display("FAIL partial_store_strobes: r=%0d w=%0d wdata=%h, required r=1 w=1 wdata=deadaaef",
               r_cnt, w_cnt, w_data);
    end
    nvec++;
    if (mem[8] !== 32'hDEAD_AAEF) begin
      nfail++;
      $display("FAIL partial_store_mem: mem[8]=%h, required deadaaef", mem[8]);
    end
  endtask

  task automatic test_empty_be_store();
    access(1'b1, 1'b1, 4'h0, 32'h0C, 32'hFFFF_FFFF, 32'h0, 1'b0, 3, "be0_store");
    nvec++;
    if (r_cnt != 0 || w_cnt != 0 || mem[3] !== 32'h1234_5678) begin
      nfail++;
      $display("FAIL be0_store_strobes: r=%0d w=%0d mem[3]=%h, required r=0 w=0 mem[3]=12345678",
               r_cnt, w_cnt, mem[3]);
    end
  endtask

  task automatic test_out_of_range();
    bd_write(8'd255, 32'hCAFE_F00D);
    access(1'b1, 1'b0, 4'h0, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0, 3, "last_word");
    access(1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 32'h0, 1'b1, 3, "oor_load");
    nvec++;
    if (r_cnt != 0 || w_cnt != 0) begin
      nfail++;
      $display("FAIL oor_load_strobes: r=%0d w=%0d, required r=0 w=0", r_cnt, w_cnt);
    end
    access(1'b1, 1'b1, 4'hF, 32'h404, 32'h5555_5555, 32'h0, 1'b1, 3, "oor_store");
    nvec++;
    if (r_cnt != 0 || w_cnt != 0) begin
      nfail++;
      $display("FAIL oor_store_strobes: r=%0d w=%0d, required r=0 w=0", r_cnt, w_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bd_write(8'd20, 32'hA5A5_0F0F);
    access(1'b0, 1'b0, 4'h0, 32'h52, 32'h0, 32'hA5A5_0F0F, 1'b0, 3, "b2b_unaligned");
    access(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 32'hDEAD_AAEF, 1'b0, 3, "b2b_if");
    access(1'b1, 1'b1, 4'b1001, 32'h50, 32'h1100_0022, 32'h0, 1'b0, 4, "b2b_rmw");
    access(1'b0, 1'b0, 4'h0, 32'h50, 32'h0, 32'h11A5_0F22, 1'b0, 3, "b2b_readback");
  endtask

  task automatic test_reset_mid_merge();
    @(posedge CLK); #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0001; dm_addr = 32'h20; dm_wdata = 32'h0000_0011;
    repeat (3) @(negedge CLK);
    nvec++;
    if (ram_w !== 1'b1) begin
      nfail++;
      $display("FAIL merge_write: ram_w=%b in cycle 3, required 1", ram_w);
    end
    RST_n = 1'b0;
    #1;
    nvec++;
    if ({ram_w, busy, dm_ack, if_ack} !== 4'b0) begin
      nfail++;
      $display("FAIL reset_mid_merge: ram_w=%b busy=%b acks=%b%b, required all 0",
               ram_w, busy, if_ack, dm_ack);
    end
    @(posedge CLK); #1;
    dm_req = 1'b0; dm_we = 1'b0;
    @(posedge CLK); #1;
    nvec++;
    if (mem[8] !== 32'hDEAD_AAEF) begin
      nfail++;
      $display("FAIL reset_mid_merge_mem: mem[8]=%h, required deadaaef", mem[8]);
    end
    @(negedge CLK); RST_n = 1'b1;
  endtask

  task automatic test_contention();
    int n;
    bit got;
    logic exp_id;
    exp_q.push_back('{id: 1'b1, rdata: 32'hDEAD_AAEF, err: 1'b0});
    exp_q.push_back('{id: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
    exp_q.push_back('{id: 1'b1, rdata: 32'hDEAD_AAEF, err: 1'b0});
    exp_q.push_back('{id: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
    @(posedge CLK); #1;
    if_req = 1'b1; if_addr = 32'h0C;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      exp_id = (k % 2 == 0);
      n = 0; got = 0;
      while (!got && n < 12) begin
        @(negedge CLK);
        n++;
        if (if_ack || dm_ack) got = 1;
      end
      nvec++;
      if (!got || n != 3 || dm_ack !== exp_id) begin
        nfail++;
        $display("FAIL contention_grant%0d: got=%b cycle=%0d dm_ack=%b, required ack cycle 3 dm_ack=%b",
                 k, got, n, dm_ack, exp_id);
      end
      @(posedge CLK); #1;
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_fetch();
    test_full_store_load();
    test_partial_store();
    test_empty_be_store();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid_merge();
    test_contention();
    repeat (4) @(posedge CLK);
    nvec++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: %0d acks outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
